// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART register-port arbiter and its bench.
//   - arb_state_t : arbiter FSM state encoding
//   - UART_REG_*  : register addresses decoded by uart_top
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic [7:0] UART_REG_CTRL   = 8'h00;
  localparam logic [7:0] UART_REG_STAT   = 8'h04;
  localparam logic [7:0] UART_REG_BAUD   = 8'h08;
  localparam logic [7:0] UART_REG_IER    = 8'h0C;
  localparam logic [7:0] UART_REG_RXDATA = 8'h10;
  localparam logic [7:0] UART_REG_TXDATA = 8'h14;

endpackage

// File: rtl/uart_reg_arb_if.sv
// uart_reg_arb_if
//   Bundles both requester ports (m0 = CPU, m1 = DMA/test engine) and the
//   register-access side towards uart_top.
//   Per requester: req, we, lock, addr[7:0], wdata[31:0] -> ack, rdata[31:0]
//   Register side: reg_addr_o[7:0], reg_wdata_o[31:0], reg_wr_o, reg_rd_o,
//                  reg_rdata_i[31:0]; status: busy_o
//   slave  : the arbiter's view
//   master : the view of the bus masters / register file model
interface uart_reg_arb_if;
  logic        m0_req;
  logic        m0_we;
  logic        m0_lock;
  logic [7:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic        m1_lock;
  logic [7:0]  m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic [31:0] m1_rdata;

  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wr_o;
  logic        reg_rd_o;
  logic [31:0] reg_rdata_i;
  logic        busy_o;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o,
    input  reg_rdata_i,
    output busy_o
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o,
    output reg_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick
//   Combinational 2-way round-robin picker with lock override.
//   req[1:0]     in   request per port
//   last_grant   in   port granted most recently
//   lock_valid   in   a locked burst is active
//   locked_port  in   owner of the active burst
//   burst_cnt    in   transfers already done in the burst
//   valid        out  at least one request present
//   winner       out  selected port
module uart_rr_pick #(
  parameter int MAX_BURST = 4
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_valid,
  input  logic       locked_port,
  input  logic [3:0] burst_cnt,
  output logic       valid,
  output logic       winner
);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (lock_valid && req[locked_port] && (burst_cnt < BURST_MAX)) begin
      winner = locked_port;
    end else if (req == 2'b11) begin
      winner = ~last_grant;
    end else begin
      // single requester (or none): port 1 only when it is the one asking
      winner = req[1];
    end
  end
endmodule

// File: rtl/uart_reg_arb.sv
// uart_reg_arb
//   Arbitrates the CPU (m0) and DMA/test engine (m1) onto the single UART
//   register-access port; one transfer in flight, round robin with locked
//   bursts. All outputs registered.
//   sclk  in  system clock
//   rstn  in  async active-low reset
//   bus   slave modport of uart_reg_arb_if (requesters + register side)
//
//   state | meaning
//   IDLE  | sample requests, pick winner, latch its transfer
//   ISSUE | address/data on reg_*, one wr or rd strobe
//   WAIT  | read latency countdown, capture reg_rdata_i on terminal count
//   DONE  | ack pulse to winner, update round-robin and burst state
module uart_reg_arb
  import uart_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic sclk,
  input  logic rstn,
  uart_reg_arb_if.slave bus
);
  localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  arb_state_t  state, state_nxt;

  logic        pick_valid, pick_port;
  logic        win_port, win_we, win_lock;
  logic        last_grant, lock_valid, locked_port;
  logic [3:0]  burst_cnt, burst_nxt;
  logic [2:0]  wait_cnt;

  logic        sel_we, sel_lock;
  logic [7:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        wait_tc, ack_set;

  uart_rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .req         ({bus.m1_req, bus.m0_req}),
    .last_grant  (last_grant),
    .lock_valid  (lock_valid),
    .locked_port (locked_port),
    .burst_cnt   (burst_cnt),
    .valid       (pick_valid),
    .winner      (pick_port)
  );

  always_comb begin
    sel_we    = pick_port ? bus.m1_we    : bus.m0_we;
    sel_lock  = pick_port ? bus.m1_lock  : bus.m0_lock;
    sel_addr  = pick_port ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = pick_port ? bus.m1_wdata : bus.m0_wdata;
    wait_tc   = (state == WAIT) && (wait_cnt == 3'd0);
    // ack register is loaded on the transition into DONE
    ack_set   = ((state == ISSUE) && win_we) || wait_tc;
    burst_nxt = burst_cnt + 4'd1;
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = win_we ? DONE : WAIT;
      WAIT:    if (wait_cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      win_port        <= 1'b0;
      win_we          <= 1'b0;
      win_lock        <= 1'b0;
      last_grant      <= 1'b1;
      lock_valid      <= 1'b0;
      locked_port     <= 1'b0;
      burst_cnt       <= 4'd0;
      wait_cnt        <= 3'd0;
      bus.m0_ack      <= 1'b0;
      bus.m1_ack      <= 1'b0;
      bus.m0_rdata    <= 32'd0;
      bus.m1_rdata    <= 32'd0;
      bus.reg_addr_o  <= 8'd0;
      bus.reg_wdata_o <= 32'd0;
      bus.reg_wr_o    <= 1'b0;
      bus.reg_rd_o    <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.m0_ack   <= ack_set & ~win_port;
      bus.m1_ack   <= ack_set &  win_port;
      bus.busy_o   <= (state_nxt != IDLE);
      bus.reg_wr_o <= 1'b0;
      bus.reg_rd_o <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_valid) begin
            win_port        <= pick_port;
            win_we          <= sel_we;
            win_lock        <= sel_lock;
            bus.reg_addr_o  <= sel_addr;
            bus.reg_wdata_o <= sel_wdata;
            bus.reg_wr_o    <= sel_we;
            bus.reg_rd_o    <= ~sel_we;
          end
        end
        ISSUE: wait_cnt <= WAIT_LOAD;
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            if (win_port) bus.m1_rdata <= bus.reg_rdata_i;
            else          bus.m0_rdata <= bus.reg_rdata_i;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE: begin
          last_grant <= win_port;
          if (win_lock) begin
            // burst that has used its quota hands off on the next tie
            if (burst_nxt >= BURST_MAX) begin
              lock_valid <= 1'b0;
              burst_cnt  <= 4'd0;
            end else begin
              lock_valid  <= 1'b1;
              locked_port <= win_port;
              burst_cnt   <= burst_nxt;
            end
          end else begin
            lock_valid <= 1'b0;
            burst_cnt  <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_reg_arb.sv
// tb_uart_reg_arb
//   Directed bench for uart_reg_arb (RD_LAT=1, MAX_BURST=4). Inputs change and
//   outputs are sampled on the falling sclk edge.
module tb_uart_reg_arb;
  import uart_pkg::*;

  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 4;

  logic sclk = 1'b0;
  logic rstn = 1'b1;
  always #5 sclk = ~sclk;

  uart_reg_arb_if bus();

  uart_reg_arb #(.RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // waits for an ack pulse on either port; port=2 means both pulsed at once
  task automatic wait_ack(input string tag, output int port, output int cycles);
    port   = -1;
    cycles = 0;
    for (int i = 0; i < 20 && port < 0; i++) begin
      @(negedge sclk);
      cycles++;
      if (bus.m0_ack && bus.m1_ack) port = 2;
      else if (bus.m0_ack)          port = 0;
      else if (bus.m1_ack)          port = 1;
    end
    chk({tag, "_ack_seen"}, (port >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic set_m0(input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
    bus.m0_addr = addr; bus.m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic lock,
                        input logic [7:0] addr, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
    bus.m1_addr = addr; bus.m1_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, c, strobes, acks;
    int exp3 [4] = '{0, 1, 0, 1};
    int exp4 [5] = '{1, 1, 1, 1, 0};

    set_m0(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    set_m1(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    bus.reg_rdata_i = 32'h0;
    #1 rstn = 1'b0;

    // reset values
    repeat (2) @(negedge sclk);
    chk("rst_busy",    32'(bus.busy_o), 32'd0);
    chk("rst_strobes", 32'({bus.reg_wr_o, bus.reg_rd_o, bus.m0_ack, bus.m1_ack}), 32'd0);
    chk("rst_addr",    32'(bus.reg_addr_o), 32'd0);
    chk("rst_rdata",   bus.m0_rdata | bus.m1_rdata, 32'd0);
    rstn = 1'b1;
    @(negedge sclk);
    chk("rst_idle", 32'(bus.busy_o), 32'd0);

    // 1: m0 write, strobe at t+1, ack at t+2
    set_m0(1'b1, 1'b1, 1'b0, UART_REG_STAT, 32'h0000_1234);
    @(negedge sclk);
    chk("t1_wr",       32'(bus.reg_wr_o), 32'd1);
    chk("t1_rd",       32'(bus.reg_rd_o), 32'd0);
    chk("t1_addr",     32'(bus.reg_addr_o), 32'h04);
    chk("t1_wdata",    bus.reg_wdata_o, 32'h0000_1234);
    chk("t1_ack_early",32'(bus.m0_ack), 32'd0);
    chk("t1_busy",     32'(bus.busy_o), 32'd1);
    @(negedge sclk);
    chk("t1_ack",      32'(bus.m0_ack), 32'd1);
    chk("t1_m1_ack",   32'(bus.m1_ack), 32'd0);
    chk("t1_wr_off",   32'(bus.reg_wr_o), 32'd0);
    bus.m0_req = 1'b0;
    @(negedge sclk);
    chk("t1_ack_pulse",32'(bus.m0_ack), 32'd0);
    chk("t1_idle",     32'(bus.busy_o), 32'd0);
    @(negedge sclk);

    // 2: m1 read, data valid at t+2, ack + rdata at t+3
    bus.reg_rdata_i = 32'hDEAD_BEEF;
    set_m1(1'b1, 1'b0, 1'b0, UART_REG_RXDATA, 32'h0);
    @(negedge sclk);
    chk("t2_rd",       32'(bus.reg_rd_o), 32'd1);
    chk("t2_wr",       32'(bus.reg_wr_o), 32'd0);
    chk("t2_addr",     32'(bus.reg_addr_o), 32'h10);
    @(negedge sclk);
    chk("t2_ack_early",32'(bus.m1_ack), 32'd0);
    chk("t2_rd_off",   32'(bus.reg_rd_o), 32'd0);
    bus.reg_rdata_i = 32'hCAFE_0001;
    @(negedge sclk);
    chk("t2_ack",      32'(bus.m1_ack), 32'd1);
    chk("t2_rdata",    bus.m1_rdata, 32'hCAFE_0001);
    chk("t2_m0_ack",   32'(bus.m0_ack), 32'd0);
    chk("t2_m0_rdata", bus.m0_rdata, 32'd0);
    bus.reg_rdata_i = 32'hDEAD_BEEF;
    bus.m1_req = 1'b0;
    @(negedge sclk);
    chk("t2_ack_pulse",32'(bus.m1_ack), 32'd0);
    chk("t2_rdata_hold", bus.m1_rdata, 32'hCAFE_0001);
    @(negedge sclk);

    // 3: both requesting, unlocked -> 0,1,0,1 at one write per 3 cycles
    set_m0(1'b1, 1'b1, 1'b0, UART_REG_CTRL, 32'h1);
    set_m1(1'b1, 1'b1, 1'b0, UART_REG_BAUD, 32'h2);
    for (int k = 0; k < 4; k++) begin
      wait_ack("t3", p, c);
      if (k == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
      chk($sformatf("t3_grant%0d", k), 32'(p), 32'(exp3[k]));
      chk($sformatf("t3_gap%0d", k), 32'(c), (k == 0) ? 32'd2 : 32'd3);
      chk($sformatf("t3_addr%0d", k), 32'(bus.reg_addr_o),
          (exp3[k] == 0) ? 32'(UART_REG_CTRL) : 32'(UART_REG_BAUD));
    end
    repeat (2) @(negedge sclk);

    // 4: m1 locked burst of MAX_BURST, then handoff to m0
    set_m1(1'b1, 1'b1, 1'b1, UART_REG_TXDATA, 32'h3);
    for (int k = 0; k < 5; k++) begin
      wait_ack("t4", p, c);
      if (k == 0) set_m0(1'b1, 1'b1, 1'b0, UART_REG_IER, 32'h4);
      if (k == 4) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
      chk($sformatf("t4_grant%0d", k), 32'(p), 32'(exp4[k]));
    end
    bus.m1_lock = 1'b0;
    repeat (2) @(negedge sclk);

    // 5: reset during read WAIT, then pending m0 write after release
    set_m0(1'b1, 1'b0, 1'b0, UART_REG_BAUD, 32'h0);
    @(negedge sclk);
    chk("t5_rd", 32'(bus.reg_rd_o), 32'd1);
    @(negedge sclk);
    chk("t5_in_wait", 32'(bus.busy_o), 32'd1);
    bus.reg_rdata_i = 32'h1111_2222;
    rstn = 1'b0;
    #1;
    chk("t5_rst_busy",    32'(bus.busy_o), 32'd0);
    chk("t5_rst_strobes", 32'({bus.reg_wr_o, bus.reg_rd_o, bus.m0_ack, bus.m1_ack}), 32'd0);
    chk("t5_rst_addr",    32'(bus.reg_addr_o), 32'd0);
    chk("t5_rst_rdata",   bus.m0_rdata | bus.m1_rdata, 32'd0);
    set_m0(1'b1, 1'b1, 1'b0, UART_REG_IER, 32'h5555);
    for (int k = 0; k < 2; k++) begin
      @(negedge sclk);
      chk($sformatf("t5_quiet%0d", k),
          32'({bus.reg_wr_o, bus.reg_rd_o, bus.m0_ack, bus.m1_ack}), 32'd0);
    end
    @(posedge sclk);
    #1 rstn = 1'b1;
    @(negedge sclk);
    chk("t5_wr_first", 32'(bus.reg_wr_o), 32'd0);
    @(negedge sclk);
    chk("t5_wr",       32'(bus.reg_wr_o), 32'd1);
    chk("t5_addr",     32'(bus.reg_addr_o), 32'h0C);
    bus.m0_req = 1'b0;
    @(negedge sclk);
    chk("t5_ack",      32'(bus.m0_ack), 32'd1);
    chk("t5_rdata",    bus.m0_rdata, 32'd0);
    repeat (2) @(negedge sclk);

    // 6: m0 drops req during ISSUE -> ack still pulses, single strobe
    strobes = 0;
    acks    = 0;
    set_m0(1'b1, 1'b1, 1'b0, UART_REG_TXDATA, 32'hABCD);
    @(negedge sclk);
    chk("t6_wr", 32'(bus.reg_wr_o), 32'd1);
    strobes += int'(bus.reg_wr_o) + int'(bus.reg_rd_o);
    acks    += int'(bus.m0_ack) + int'(bus.m1_ack);
    bus.m0_req = 1'b0;
    @(negedge sclk);
    chk("t6_ack", 32'(bus.m0_ack), 32'd1);
    strobes += int'(bus.reg_wr_o) + int'(bus.reg_rd_o);
    acks    += int'(bus.m0_ack) + int'(bus.m1_ack);
    repeat (4) begin
      @(negedge sclk);
      strobes += int'(bus.reg_wr_o) + int'(bus.reg_rd_o);
      acks    += int'(bus.m0_ack) + int'(bus.m1_ack);
    end
    chk("t6_strobes", 32'(strobes), 32'd1);
    chk("t6_acks",    32'(acks), 32'd1);
    chk("t6_idle",    32'(bus.busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
